gpr_bank: RTL and testbench

Parametrised general-purpose register file for the datapath. It provides two registered read ports, one write port, and a dedicated high-result register for wide multiply results. A per-register pending scoreboard lets the issue logic reserve a destination and stall reads of it until the write arrives. Reads and writes may occur in the same cycle, with write-to-read bypass. It sits between the decode/issue stage (read side) and the writeback stage (write side).

---
 rtl/gpr_bank.sv | 120 ++++++++++++
 tb/tb_gpr_bank.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_bank.sv
// gpr_bank: general-purpose register file with two registered read ports,
// one write port with write-to-read bypass, a separate high-result register
// and a per-register pending scoreboard used to stall reads of reserved
// destinations until their writeback arrives.
module gpr_bank #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned ZERO_REG  = 0,
  localparam int unsigned ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdEn,
  input  logic [ADDR_W-1:0]    rdA_num,
  input  logic [ADDR_W-1:0]    rdB_num,
  output logic                 rdStall,
  output logic [DATA_W-1:0]    rdA_out,
  output logic [DATA_W-1:0]    rdB_out,
  output logic                 rdValid,
  input  logic                 wrEn,
  input  logic [ADDR_W-1:0]    wrC_num,
  input  logic [DATA_W-1:0]    wrC_in,
  input  logic                 hiWrEn,
  input  logic [DATA_W-1:0]    hi_in,
  output logic [DATA_W-1:0]    hi_out,
  input  logic                 rsvEn,
  input  logic [ADDR_W-1:0]    rsv_num,
  output logic [REG_COUNT-1:0] pending
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]    mem_q [REG_COUNT];
  logic [DATA_W-1:0]    mem_d [REG_COUNT];
  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]    rd_a_q, rd_a_d;
  logic [DATA_W-1:0]    rd_b_q, rd_b_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    hi_q, hi_d;

  logic                 eff_wr;
  logic                 eff_rsv;
  logic                 a_blocked;
  logic                 b_blocked;
  logic                 rd_accept;
  logic [DATA_W-1:0]    rd_a_val;
  logic [DATA_W-1:0]    rd_b_val;

  // Qualify write/reserve requests and decide whether the read can issue;
  // a write landing this cycle unblocks its own pending register.
  always_comb begin
    eff_wr    = wrEn && !(ZERO_EN && (wrC_num == '0));
    eff_rsv   = rsvEn && !(ZERO_EN && (rsv_num == '0));
    a_blocked = pending_q[rdA_num] && !(eff_wr && (wrC_num == rdA_num));
    b_blocked = pending_q[rdB_num] && !(eff_wr && (wrC_num == rdB_num));
    rdStall   = rdEn && (a_blocked || b_blocked);
    rd_accept = rdEn && !rdStall;
  end

  // Operand selection: hardwired zero beats bypass, bypass beats array.
  always_comb begin
    rd_a_val = mem_q[rdA_num];
    rd_b_val = mem_q[rdB_num];
    if (eff_wr && (wrC_num == rdA_num)) rd_a_val = wrC_in;
    if (eff_wr && (wrC_num == rdB_num)) rd_b_val = wrC_in;
    if (ZERO_EN && (rdA_num == '0)) rd_a_val = '0;
    if (ZERO_EN && (rdB_num == '0)) rd_b_val = '0;
  end

  // Next state for array, scoreboard (reserve set wins over write clear),
  // read registers and high register.
  always_comb begin
    mem_d      = mem_q;
    pending_d  = pending_q;
    rd_a_d     = rd_a_q;
    rd_b_d     = rd_b_q;
    rd_valid_d = rd_accept;
    hi_d       = hi_q;
    if (eff_wr) begin
      mem_d[wrC_num]     = wrC_in;
      pending_d[wrC_num] = 1'b0;
    end
    if (eff_rsv) begin
      pending_d[rsv_num] = 1'b1;
    end
    if (rd_accept) begin
      rd_a_d = rd_a_val;
      rd_b_d = rd_b_val;
    end
    if (hiWrEn) begin
      hi_d = hi_in;
    end
  end

  // State registers; reset clears everything and drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      pending_q  <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_valid_q <= 1'b0;
      hi_q       <= '0;
    end else begin
      mem_q      <= mem_d;
      pending_q  <= pending_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      rd_valid_q <= rd_valid_d;
      hi_q       <= hi_d;
    end
  end

  assign rdA_out = rd_a_q;
  assign rdB_out = rd_b_q;
  assign rdValid = rd_valid_q;
  assign hi_out  = hi_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: directed tests for gpr_bank, one default instance
// (8x8, no zero register) and one 16x16 instance with a zero register.
module tb_gpr_bank;

  logic        clk;
  logic        rst_n;

  logic        rdEn, rdStall, rdValid, wrEn, hiWrEn, rsvEn;
  logic [2:0]  rdA_num, rdB_num, wrC_num, rsv_num;
  logic [7:0]  rdA_out, rdB_out, wrC_in, hi_in, hi_out, pending;

  logic        p_rdEn, p_rdStall, p_rdValid, p_wrEn, p_hiWrEn, p_rsvEn;
  logic [3:0]  p_rdA_num, p_rdB_num, p_wrC_num, p_rsv_num;
  logic [15:0] p_rdA_out, p_rdB_out, p_wrC_in, p_hi_in, p_hi_out, p_pending;

  int tests_run;
  int tests_failed;

  gpr_bank #(.DATA_W(8), .REG_COUNT(8), .ZERO_REG(0)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .rdEn(rdEn), .rdA_num(rdA_num), .rdB_num(rdB_num), .rdStall(rdStall),
    .rdA_out(rdA_out), .rdB_out(rdB_out), .rdValid(rdValid),
    .wrEn(wrEn), .wrC_num(wrC_num), .wrC_in(wrC_in),
    .hiWrEn(hiWrEn), .hi_in(hi_in), .hi_out(hi_out),
    .rsvEn(rsvEn), .rsv_num(rsv_num), .pending(pending)
  );

  gpr_bank #(.DATA_W(16), .REG_COUNT(16), .ZERO_REG(1)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .rdEn(p_rdEn), .rdA_num(p_rdA_num), .rdB_num(p_rdB_num), .rdStall(p_rdStall),
    .rdA_out(p_rdA_out), .rdB_out(p_rdB_out), .rdValid(p_rdValid),
    .wrEn(p_wrEn), .wrC_num(p_wrC_num), .wrC_in(p_wrC_in),
    .hiWrEn(p_hiWrEn), .hi_in(p_hi_in), .hi_out(p_hi_out),
    .rsvEn(p_rsvEn), .rsv_num(p_rsv_num), .pending(p_pending)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wrEn = 1; wrC_num = 3; wrC_in = 8'h77;
    hiWrEn = 1; hi_in = 8'h99;
    rsvEn = 1; rsv_num = 2;
    tick();
    wrEn = 0; hiWrEn = 0; rsvEn = 0;
    tests_run++;
    if (hi_out !== 8'h99) begin tests_failed++; $display("[TB] FAIL pre_reset_hi: got %h expected %h", hi_out, 8'h99); end
    tests_run++;
    if (pending !== 8'h04) begin tests_failed++; $display("[TB] FAIL pre_reset_pending: got %h expected %h", pending, 8'h04); end
    rdEn = 1; rdA_num = 3; rdB_num = 3;
    #2 rst_n = 0;
    #1;
    tests_run++;
    if (rdA_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rdA: got %h expected %h", rdA_out, 8'h00); end
    tests_run++;
    if (rdB_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rdB: got %h expected %h", rdB_out, 8'h00); end
    tests_run++;
    if (hi_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h expected %h", hi_out, 8'h00); end
    tests_run++;
    if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_pending: got %h expected %h", pending, 8'h00); end
    tests_run++;
    if (rdValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rdValid: got %b expected %b", rdValid, 1'b0); end
    rdEn = 0;
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    tests_run++;
    if (rdValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_rdValid: got %b expected %b", rdValid, 1'b0); end
    rdEn = 1; rdA_num = 3; rdB_num = 3;
    tick();
    rdEn = 0;
    tests_run++;
    if (rdA_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_r3_cleared: got %h expected %h", rdA_out, 8'h00); end
    tests_run++;
    if (rdValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_read_valid: got %b expected %b", rdValid, 1'b1); end
    tick();
    tests_run++;
    if (rdValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_one_cycle: got %b expected %b", rdValid, 1'b0); end
  endtask

  task automatic test_write_read();
    wrEn = 1; wrC_num = 5; wrC_in = 8'hA7;
    tick();
    wrEn = 0;
    rdEn = 1; rdA_num = 5; rdB_num = 5;
    tick();
    tests_run++;
    if (rdA_out !== 8'hA7) begin tests_failed++; $display("[TB] FAIL wr_rd_A: got %h expected %h", rdA_out, 8'hA7); end
    tests_run++;
    if (rdB_out !== 8'hA7) begin tests_failed++; $display("[TB] FAIL wr_rd_B: got %h expected %h", rdB_out, 8'hA7); end
    tests_run++;
    if (rdValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_rd_valid: got %b expected %b", rdValid, 1'b1); end
    wrEn = 1; wrC_num = 2; wrC_in = 8'h3C;
    rdA_num = 2; rdB_num = 5;
    tick();
    wrEn = 0; rdEn = 0;
    tests_run++;
    if (rdA_out !== 8'h3C) begin tests_failed++; $display("[TB] FAIL bypass_A: got %h expected %h", rdA_out, 8'h3C); end
    tests_run++;
    if (rdB_out !== 8'hA7) begin tests_failed++; $display("[TB] FAIL bypass_other_B: got %h expected %h", rdB_out, 8'hA7); end
    tests_run++;
    if (rdValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL back_to_back_valid: got %b expected %b", rdValid, 1'b1); end
    tick();
  endtask

  task automatic test_stall();
    rsvEn = 1; rsv_num = 4;
    tick();
    rsvEn = 0;
    tests_run++;
    if (pending !== 8'h10) begin tests_failed++; $display("[TB] FAIL rsv_r4_pending: got %h expected %h", pending, 8'h10); end
    rdEn = 1; rdA_num = 4; rdB_num = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (rdStall !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_A_cycle%0d: got %b expected %b", i, rdStall, 1'b1); end
      tick();
      tests_run++;
      if (rdValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_valid_cycle%0d: got %b expected %b", i, rdValid, 1'b0); end
      tests_run++;
      if (rdA_out !== 8'h3C) begin tests_failed++; $display("[TB] FAIL stall_hold_A_cycle%0d: got %h expected %h", i, rdA_out, 8'h3C); end
    end
    wrEn = 1; wrC_num = 4; wrC_in = 8'h55;
    #1;
    tests_run++;
    if (rdStall !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_unstall: got %b expected %b", rdStall, 1'b0); end
    tick();
    wrEn = 0; rdEn = 0;
    tests_run++;
    if (rdA_out !== 8'h55) begin tests_failed++; $display("[TB] FAIL unstall_A: got %h expected %h", rdA_out, 8'h55); end
    tests_run++;
    if (rdValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL unstall_valid: got %b expected %b", rdValid, 1'b1); end
    tests_run++;
    if (pending !== 8'h00) begin tests_failed++; $display("[TB] FAIL unstall_pending: got %h expected %h", pending, 8'h00); end
    rsvEn = 1; rsv_num = 7;
    tick();
    rsvEn = 0;
    rdEn = 1; rdA_num = 5; rdB_num = 7;
    #1;
    tests_run++;
    if (rdStall !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_B: got %b expected %b", rdStall, 1'b1); end
    tick();
    tests_run++;
    if (rdValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_B_valid: got %b expected %b", rdValid, 1'b0); end
    wrEn = 1; wrC_num = 7; wrC_in = 8'h0E;
    tick();
    wrEn = 0; rdEn = 0;
    tests_run++;
    if (rdB_out !== 8'h0E) begin tests_failed++; $display("[TB] FAIL unstall_B: got %h expected %h", rdB_out, 8'h0E); end
    tests_run++;
    if (rdA_out !== 8'hA7) begin tests_failed++; $display("[TB] FAIL unstall_B_A: got %h expected %h", rdA_out, 8'hA7); end
  endtask

  task automatic test_rsv_read_same_cycle();
    rsvEn = 1; rsv_num = 3;
    rdEn = 1; rdA_num = 3; rdB_num = 3;
    #1;
    tests_run++;
    if (rdStall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rsv_same_cycle_stall: got %b expected %b", rdStall, 1'b0); end
    tick();
    rsvEn = 0;
    tests_run++;
    if (rdValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rsv_same_cycle_valid: got %b expected %b", rdValid, 1'b1); end
    tests_run++;
    if (rdA_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL rsv_same_cycle_A: got %h expected %h", rdA_out, 8'h00); end
    tests_run++;
    if (pending !== 8'h08) begin tests_failed++; $display("[TB] FAIL rsv_same_cycle_pending: got %h expected %h", pending, 8'h08); end
    #1;
    tests_run++;
    if (rdStall !== 1'b1) begin tests_failed++; $display("[TB] FAIL rsv_next_cycle_stall: got %b expected %b", rdStall, 1'b1); end
    rdEn = 0;
    wrEn = 1; wrC_num = 3; wrC_in = 8'h00;
    tick();
    wrEn = 0;
  endtask

  task automatic test_collision();
    rsvEn = 1; rsv_num = 6;
    wrEn = 1; wrC_num = 6; wrC_in = 8'h11;
    tick();
    wrEn = 0;
    tests_run++;
    if (pending !== 8'h40) begin tests_failed++; $display("[TB] FAIL collision_pending: got %h expected %h", pending, 8'h40); end
    tests_run++;
    if (dut8.mem_q[6] !== 8'h11) begin tests_failed++; $display("[TB] FAIL collision_data: got %h expected %h", dut8.mem_q[6], 8'h11); end
    tick();
    rsvEn = 0;
    tests_run++;
    if (pending !== 8'h40) begin tests_failed++; $display("[TB] FAIL rerserve_pending: got %h expected %h", pending, 8'h40); end
    wrEn = 1; wrC_num = 6; wrC_in = 8'h22;
    tick();
    wrEn = 0;
    rdEn = 1; rdA_num = 6; rdB_num = 2;
    tick();
    rdEn = 0;
    tests_run++;
    if (rdA_out !== 8'h22) begin tests_failed++; $display("[TB] FAIL collision_readback: got %h expected %h", rdA_out, 8'h22); end
    tests_run++;
    if (rdB_out !== 8'h3C) begin tests_failed++; $display("[TB] FAIL collision_r2: got %h expected %h", rdB_out, 8'h3C); end
  endtask

  task automatic test_hi();
    wrEn = 1; wrC_num = 1; wrC_in = 8'h34;
    hiWrEn = 1; hi_in = 8'h12;
    tick();
    wrEn = 0; hiWrEn = 0; hi_in = 8'hEE;
    tests_run++;
    if (hi_out !== 8'h12) begin tests_failed++; $display("[TB] FAIL hi_load: got %h expected %h", hi_out, 8'h12); end
    rdEn = 1; rdA_num = 1; rdB_num = 1;
    tick();
    rdEn = 0;
    tests_run++;
    if (rdA_out !== 8'h34) begin tests_failed++; $display("[TB] FAIL hi_r1_A: got %h expected %h", rdA_out, 8'h34); end
    tests_run++;
    if (hi_out !== 8'h12) begin tests_failed++; $display("[TB] FAIL hi_hold: got %h expected %h", hi_out, 8'h12); end
  endtask

  task automatic test_params();
    p_wrEn = 1; p_wrC_num = 0; p_wrC_in = 16'hFFFF;
    p_rdEn = 1; p_rdA_num = 0; p_rdB_num = 15;
    tick();
    p_wrEn = 0;
    tests_run++;
    if (p_rdA_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL zero_bypass: got %h expected %h", p_rdA_out, 16'h0000); end
    p_rdA_num = 0; p_rdB_num = 0;
    tick();
    p_rdEn = 0;
    tests_run++;
    if (p_rdB_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL zero_read: got %h expected %h", p_rdB_out, 16'h0000); end
    tests_run++;
    if (p_rdValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_read_valid: got %b expected %b", p_rdValid, 1'b1); end
    p_rsvEn = 1; p_rsv_num = 0;
    tick();
    p_rsvEn = 0;
    tests_run++;
    if (p_pending !== 16'h0000) begin tests_failed++; $display("[TB] FAIL zero_rsv_pending: got %h expected %h", p_pending, 16'h0000); end
    p_rdEn = 1; p_rdA_num = 0; p_rdB_num = 0;
    #1;
    tests_run++;
    if (p_rdStall !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_rsv_stall: got %b expected %b", p_rdStall, 1'b0); end
    p_rdEn = 0;
    p_wrEn = 1; p_wrC_num = 15; p_wrC_in = 16'hBEEF;
    tick();
    p_wrEn = 0;
    p_rdEn = 1; p_rdA_num = 15; p_rdB_num = 15;
    tick();
    p_rdEn = 0;
    tests_run++;
    if (p_rdA_out !== 16'hBEEF) begin tests_failed++; $display("[TB] FAIL r15_A: got %h expected %h", p_rdA_out, 16'hBEEF); end
    tests_run++;
    if (p_rdB_out !== 16'hBEEF) begin tests_failed++; $display("[TB] FAIL r15_B: got %h expected %h", p_rdB_out, 16'hBEEF); end
  endtask

  // Test sequence.
  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 0;
    rdEn = 0; rdA_num = 0; rdB_num = 0;
    wrEn = 0; wrC_num = 0; wrC_in = 0;
    hiWrEn = 0; hi_in = 0; rsvEn = 0; rsv_num = 0;
    p_rdEn = 0; p_rdA_num = 0; p_rdB_num = 0;
    p_wrEn = 0; p_wrC_num = 0; p_wrC_in = 0;
    p_hiWrEn = 0; p_hi_in = 0; p_rsvEn = 0; p_rsv_num = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    test_reset();
    test_write_read();
    test_stall();
    test_rsv_read_same_cycle();
    test_collision();
    test_hi();
    test_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
